// File: rtl/game_input_cond.sv
// Conditions mouse buttons and the partner-board GPIO start line into single-cycle press pulses.
// Latency: 2 cycles (mouse, edge only) / 1+DEBOUNCE_CYCLES (debounced); no backpressure. Macro MOUSE_DEBOUNCE_EN debounces the mouse paths too.
module game_input_cond #(
    parameter int  DEBOUNCE_CYCLES = 65000,
    localparam int CNT_W           = $clog2(DEBOUNCE_CYCLES)
) (
    input  logic clk,
    input  logic rst,
    input  logic m_left_raw,
    input  logic m_right_raw,
    input  logic gpio_raw,
    output logic m_left,
    output logic m_right,
    output logic gpio,
    output logic gpio_level
);

`ifdef MOUSE_DEBOUNCE_EN
    localparam int FIRST_DB = 0;
`else
    localparam int FIRST_DB = 2;
`endif

    // Channel order: 0 = left, 1 = right, 2 = gpio.
    logic [2:0] raw;
    logic [2:0] s1;
    logic [2:0] s2;
    logic [2:0] pulses;
    logic [1:0] fill;

    assign raw = {gpio_raw, m_right_raw, m_left_raw};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1   <= '0;
            s2   <= '0;
            fill <= '0;
        end else begin
            s1 <= raw;
            s2 <= s1;
            if (!fill[1]) fill <= fill + 2'd1;
        end
    end

    // The cleared sync chain is not an observation of the pin: arming waits
    // until s2 holds a real sample, so a level held through reset cannot arm.
    for (genvar i = 0; i < 3; i++) begin : g_ch
        logic armed;
        logic pulse;

        if (i < FIRST_DB) begin : g_edge
            logic s3;

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    s3    <= 1'b0;
                    armed <= 1'b0;
                    pulse <= 1'b0;
                end else begin
                    s3    <= s2[i];
                    armed <= armed | (fill[1] & ~s2[i]);
                    pulse <= s2[i] & ~s3 & armed;
                end
            end
        end else begin : g_db
            logic [CNT_W-1:0] cnt;
            logic             lvl;

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    cnt   <= '0;
                    lvl   <= 1'b0;
                    armed <= 1'b0;
                    pulse <= 1'b0;
                end else begin
                    armed <= armed | (fill[1] & ~lvl & ~s2[i]);
                    pulse <= 1'b0;
                    if (s2[i] == lvl) begin
                        cnt <= '0;
                    end else if (cnt == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
                        lvl   <= s2[i];
                        cnt   <= '0;
                        pulse <= s2[i] & armed;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
            end
        end

        assign pulses[i] = pulse;
    end

    assign {gpio, m_right, m_left} = pulses;
    assign gpio_level              = g_ch[2].g_db.lvl;

endmodule

// File: tb/tb_game_input_cond.sv
// Scoreboard bench for game_input_cond with DEBOUNCE_CYCLES=4; edge numbers count posedges from time 0.
module tb_game_input_cond;
    localparam int D = 4;
`ifdef MOUSE_DEBOUNCE_EN
    localparam int LAT_M = 1 + D;
`else
    localparam int LAT_M = 2;
`endif
    localparam int LAT_G = 1 + D;

    logic clk, rst;
    logic m_left_raw, m_right_raw, gpio_raw;
    logic m_left, m_right, gpio, gpio_level;

    int cyc    = 0;
    int checks = 0;
    int errors = 0;

    typedef struct {
        int         cyc;
        logic [2:0] vec;
    } exp_t;
    exp_t exp_q[$];

    game_input_cond #(.DEBOUNCE_CYCLES(D)) dut (
        .clk        (clk),
        .rst        (rst),
        .m_left_raw (m_left_raw),
        .m_right_raw(m_right_raw),
        .gpio_raw   (gpio_raw),
        .m_left     (m_left),
        .m_right    (m_right),
        .gpio       (gpio),
        .gpio_level (gpio_level)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc++;

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (edge %0d)", name, act, req, cyc);
        end
    endtask

    task automatic expect_pulse(input int c, input logic [2:0] v);
        exp_t e;
        e.cyc = c;
        e.vec = v;
        exp_q.push_back(e);
    endtask

    // Returns at the negedge just before edge n, so inputs set now are sampled at edge n.
    task automatic to_edge(input int n);
        wait (cyc >= n - 1);
        @(negedge clk);
    endtask

    task automatic chk_outputs_zero(input string tag);
        chk({tag, "_m_left"}, m_left, 0);
        chk({tag, "_m_right"}, m_right, 0);
        chk({tag, "_gpio"}, gpio, 0);
        chk({tag, "_gpio_level"}, gpio_level, 0);
    endtask

    always @(negedge clk) begin : monitor
        logic [2:0] v;
        exp_t       e;
        v = {gpio, m_right, m_left};
        if (v != 3'b000) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_pulse", int'(v), 0);
            end else begin
                e = exp_q.pop_front();
                chk("pulse_edge", cyc, e.cyc);
                chk("pulse_vec", int'(v), int'(e.vec));
                if (v[2]) chk("gpio_level_at_pulse", gpio_level, 1);
            end
        end
    end

    initial begin
        #20000;
        $display("FAIL watchdog: simulation did not complete, edge %0d", cyc);
        $fatal(1);
    end

    initial begin
        int t;
        rst         = 1'b1;
        m_left_raw  = 1'b0;
        m_right_raw = 1'b0;
        gpio_raw    = 1'b0;
        @(posedge clk);
        #1;
        chk_outputs_zero("reset");
        to_edge(3);
        rst = 1'b0;

        // Single left press, held.
        to_edge(10);
        m_left_raw = 1'b1;
        expect_pulse(10 + LAT_M, 3'b001);
        to_edge(18);
        m_left_raw = 1'b0;

        // Clean GPIO press and later release.
        to_edge(20);
        gpio_raw = 1'b1;
        expect_pulse(20 + LAT_G, 3'b100);
        to_edge(25);
        chk("gpio_level_before_accept", gpio_level, 0);
        to_edge(27);
        chk("gpio_level_held", gpio_level, 1);
        chk("gpio_single_cycle", gpio, 0);
        to_edge(30);
        gpio_raw = 1'b0;
        to_edge(36);
        chk("gpio_level_fall", gpio_level, 0);

        // Glitches of 1..3 cycles, twice over.
        t = 40;
        for (int rep = 0; rep < 2; rep++) begin
            for (int len = 1; len <= 3; len++) begin
                to_edge(t);
                gpio_raw = 1'b1;
                to_edge(t + len);
                gpio_raw = 1'b0;
                to_edge(t + len + 2);
                chk("glitch_level", gpio_level, 0);
                t = t + len + 3;
            end
        end

        // Simultaneous left and right presses.
        to_edge(80);
        m_left_raw  = 1'b1;
        m_right_raw = 1'b1;
        expect_pulse(80 + LAT_M, 3'b011);
        to_edge(88);
        m_left_raw  = 1'b0;
        m_right_raw = 1'b0;

        // Right button held through reset: silent until released and re-pressed.
        to_edge(92);
        m_right_raw = 1'b1;
        rst         = 1'b1;
        #1;
        chk_outputs_zero("reset_hold");
        to_edge(95);
        rst = 1'b0;
        to_edge(105);
        m_right_raw = 1'b0;
        to_edge(110);
        m_right_raw = 1'b1;
        expect_pulse(110 + LAT_M, 3'b010);
        to_edge(118);
        m_right_raw = 1'b0;

        // Reset two cycles into a GPIO debounce; after release the line stays high.
        to_edge(120);
        gpio_raw = 1'b1;
        to_edge(124);
        rst = 1'b1;
        #1;
        chk("mid_debounce_gpio_level", gpio_level, 0);
        chk("mid_debounce_gpio", gpio, 0);
        to_edge(126);
        rst = 1'b0;
        to_edge(135);
        chk("unarmed_level_rises", gpio_level, 1);

        // Asynchronous clear of a high debounced level, between clock edges.
        rst = 1'b1;
        #1;
        chk("async_clear_gpio_level", gpio_level, 0);
        to_edge(138);
        rst      = 1'b0;
        gpio_raw = 1'b0;

        to_edge(145);
        chk("missing_pulses", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
